// File: rtl/cs_resolve_pkg.sv
// Shared types and sizing helpers for the chunked carry-save resolver.
package cs_resolve_pkg;

    localparam int DEF_WIDTH = 94;
    localparam int DEF_CHUNK = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    function automatic int calc_nseg(input int width, input int chunk);
        return (width + chunk - 1) / chunk;
    endfunction

endpackage

// File: rtl/cs_resolve_94_chunk_add.sv
// cs_chunk_add: combinational CHUNK-bit adder with carry-in and carry-out.
module cs_chunk_add
    import cs_resolve_pkg::*;
#(
    parameter int CHUNK = DEF_CHUNK
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             ci,
    output logic [CHUNK-1:0] s,
    output logic             co
);

    assign {co, s} = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, ci};

endmodule

// File: rtl/cs_resolve_94.sv
// Sequential carry-propagate resolver: adds a carry-save pair CHUNK bits per cycle.
// Optional carry-out port enabled by defining CS_RESOLVE_COUT_EN.
module cs_resolve_94
    import cs_resolve_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CHUNK = DEF_CHUNK
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] c_in,
    input  logic [WIDTH-1:0] s_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum
`ifdef CS_RESOLVE_COUT_EN
    ,
    output logic             cout
`endif
);

    localparam int NSEG  = calc_nseg(WIDTH, CHUNK);
    localparam int LASTW = WIDTH - (NSEG - 1) * CHUNK;
    localparam int SEGW  = (NSEG > 1) ? $clog2(NSEG) : 1;
    localparam int IDXW  = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [SEGW-1:0] SEG_LAST = SEGW'(NSEG - 1);

    state_e            state_q, state_d;
    logic [SEGW-1:0]   seg_q, seg_d;
    logic              carry_q, carry_d;
    logic [WIDTH-1:0]  c_q, c_d;
    logic [WIDTH-1:0]  s_q, s_d;
    logic [WIDTH-1:0]  sum_q, sum_d;
    logic              out_valid_q, out_valid_d;
`ifdef CS_RESOLVE_COUT_EN
    logic              cout_q, cout_d;
`endif

    logic [IDXW-1:0]   base_s;
    logic [CHUNK-1:0]  c_chunk_s;
    logic [CHUNK-1:0]  s_chunk_s;
    logic [CHUNK-1:0]  add_s_s;
    logic              add_co_s;
    logic              last_carry_s;
    logic [WIDTH-1:0]  wr_mask_s;
    logic [WIDTH-1:0]  wr_bits_s;

    // Segment mux: shifting right zero-fills the short top segment.
    assign base_s    = IDXW'(int'(seg_q) * CHUNK);
    assign c_chunk_s = CHUNK'(c_q >> base_s);
    assign s_chunk_s = CHUNK'(s_q >> base_s);
    assign wr_mask_s = WIDTH'({CHUNK{1'b1}}) << base_s;
    assign wr_bits_s = WIDTH'(add_s_s) << base_s;

    cs_chunk_add #(
        .CHUNK (CHUNK)
    ) u_chunk_add (
        .a  (c_chunk_s),
        .b  (s_chunk_s),
        .ci (carry_q),
        .s  (add_s_s),
        .co (add_co_s)
    );

    // The top segment is LASTW wide, so its carry sits at adder bit LASTW.
    if (LASTW < CHUNK) begin : g_short_last
        assign last_carry_s = add_s_s[LASTW];
    end else begin : g_full_last
        assign last_carry_s = add_co_s;
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = out_valid_q;
    assign sum       = sum_q;
`ifdef CS_RESOLVE_COUT_EN
    assign cout      = cout_q;
`endif

    // Next-state, segment sequencing and result accumulation.
    always_comb begin
        state_d     = state_q;
        seg_d       = seg_q;
        carry_d     = carry_q;
        c_d         = c_q;
        s_d         = s_q;
        sum_d       = sum_q;
        out_valid_d = out_valid_q;
`ifdef CS_RESOLVE_COUT_EN
        cout_d      = cout_q;
`endif
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    c_d     = c_in;
                    s_d     = s_in;
                    carry_d = 1'b0;
                    sum_d   = {WIDTH{1'b0}};
                    seg_d   = {SEGW{1'b0}};
                    state_d = RUN;
`ifdef CS_RESOLVE_COUT_EN
                    cout_d  = 1'b0;
`endif
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                sum_d = (sum_q & ~wr_mask_s) | (wr_bits_s & wr_mask_s);
                if (seg_q == SEG_LAST) begin
                    carry_d     = last_carry_s;
                    out_valid_d = 1'b1;
                    state_d     = DONE;
`ifdef CS_RESOLVE_COUT_EN
                    cout_d      = last_carry_s;
`endif
                end else begin
                    carry_d = add_co_s;
                    seg_d   = seg_q + SEGW'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end else begin
                    state_d = DONE;
                end
            end
            default: begin
                out_valid_d = 1'b0;
                state_d     = IDLE;
            end
        endcase
    end

    // State, operand copies and result registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            seg_q       <= {SEGW{1'b0}};
            carry_q     <= 1'b0;
            c_q         <= {WIDTH{1'b0}};
            s_q         <= {WIDTH{1'b0}};
            sum_q       <= {WIDTH{1'b0}};
            out_valid_q <= 1'b0;
`ifdef CS_RESOLVE_COUT_EN
            cout_q      <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            seg_q       <= seg_d;
            carry_q     <= carry_d;
            c_q         <= c_d;
            s_q         <= s_d;
            sum_q       <= sum_d;
            out_valid_q <= out_valid_d;
`ifdef CS_RESOLVE_COUT_EN
            cout_q      <= cout_d;
`endif
        end
    end

endmodule

// File: tb/tb_cs_resolve_94.sv
// Directed and random bench for cs_resolve_94 with a scoreboard of WIDTH+1-bit sums.
// Works in both builds (CS_RESOLVE_COUT_EN defined or not).
module tb_cs_resolve_94;

    localparam int W = 94;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] c_in;
    logic [W-1:0] s_in;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
`ifdef CS_RESOLVE_COUT_EN
    logic         cout;
`endif

    logic [W:0] exp_q[$];
    int         total = 0;
    int         bad   = 0;
    time        t_acc = 0;
    time        t_prev = 0;

    always #5 clk = ~clk;

    cs_resolve_94 dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .c_in      (c_in),
        .s_in      (s_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum)
`ifdef CS_RESOLVE_COUT_EN
        ,
        .cout      (cout)
`endif
    );

    function automatic logic [W-1:0] rnd_vec();
        logic [95:0] r;
        r = {$urandom, $urandom, $urandom};
        return r[W-1:0];
    endfunction

    function automatic logic [W:0] result_obs();
`ifdef CS_RESOLVE_COUT_EN
        return {cout, sum};
`else
        return {1'b0, sum};
`endif
    endfunction

    function automatic logic [W:0] model_view(input logic [W:0] e);
`ifdef CS_RESOLVE_COUT_EN
        return e;
`else
        return {1'b0, e[W-1:0]};
`endif
    endfunction

    task automatic check(input string tag, input logic [W:0] obs, input logic [W:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge following the acceptance edge.
    task automatic do_accept(input logic [W-1:0] c, input logic [W-1:0] s);
        int n;
        n = 0;
        while (in_ready !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check_bit("accept_ready", in_ready, 1'b1);
        c_in     = c;
        s_in     = s;
        in_valid = 1'b1;
        exp_q.push_back({1'b0, c} + {1'b0, s});
        @(posedge clk);
        t_prev = t_acc;
        t_acc  = $time;
        #1;
        in_valid = 1'b0;
        c_in     = rnd_vec();
        s_in     = rnd_vec();
        @(negedge clk);
    endtask

    task automatic expect_result(input string tag, input int hold);
        logic [W:0] e;
        logic       saved_ready;
        saved_ready = out_ready;
        e = '0;
        repeat (5) @(negedge clk);
        check_bit({tag, "_valid_early"}, out_valid, 1'b0);
        @(negedge clk);
        check_bit({tag, "_valid"}, out_valid, 1'b1);
        check_bit({tag, "_busy"}, in_ready, 1'b0);
        check_bit({tag, "_sb_nonempty"}, exp_q.size() != 0, 1'b1);
        if (exp_q.size() != 0) e = exp_q.pop_front();
        check({tag, "_sum"}, result_obs(), model_view(e));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check({tag, "_hold_sum"}, result_obs(), model_view(e));
            check_bit({tag, "_hold_valid"}, out_valid, 1'b1);
            check_bit({tag, "_hold_busy"}, in_ready, 1'b0);
        end
        out_ready = 1'b1;
        #1;
        check_bit({tag, "_turn_busy"}, in_ready, 1'b0);
        @(negedge clk);
        check_bit({tag, "_valid_drop"}, out_valid, 1'b0);
        check_bit({tag, "_idle_ready"}, in_ready, 1'b1);
        out_ready = saved_ready;
    endtask

    initial begin
        logic [W-1:0] ones;
        int           seen;
        ones      = {W{1'b1}};
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        c_in      = {W{1'b0}};
        s_in      = {W{1'b0}};

        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_bit("reset_in_ready", in_ready, 1'b1);
        check_bit("reset_out_valid", out_valid, 1'b0);
        check("reset_result", result_obs(), {(W+1){1'b0}});

        do_accept({W{1'b0}}, W'(5));
        expect_result("simple", 0);

        do_accept(W'(2), ones);
        expect_result("ripple", 0);

        do_accept(W'(1), W'(1));
        expect_result("c0_set", 0);

        do_accept(ones, ones);
        expect_result("max_max", 0);

        do_accept(rnd_vec(), rnd_vec());
        expect_result("backpressure", 10);

        do_accept(rnd_vec(), rnd_vec());
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        check_bit("midrst_in_ready", in_ready, 1'b1);
        check_bit("midrst_out_valid", out_valid, 1'b0);
        check("midrst_result", result_obs(), {(W+1){1'b0}});
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst  = 1'b0;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (out_valid === 1'b1) seen++;
        end
        check("midrst_no_valid", (W+1)'(seen), {(W+1){1'b0}});
        check_bit("midrst_idle", in_ready, 1'b1);

        do_accept(W'(7), W'(9));
        expect_result("after_rst", 0);

        out_ready = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            do_accept(rnd_vec(), rnd_vec());
            if (i > 0) check("spacing", (W+1)'((t_acc - t_prev) / 10), (W+1)'(8));
            expect_result("rand", 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
